truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter DWELL, default 2: clock cycles each input combination is held; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a full 16-combination sweep.
REQ-005 A, B, C, D  output  1 each  stimulus to the downstream 4-input combinational block; A is the MSB of the combination index.
REQ-006 f, g, h  input  1 each  combinational responses returned from the downstream block.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  single-cycle pulse when a sweep completes.
REQ-009 index  output  4  combination currently applied; equals {A,B,C,D}.
REQ-010 f_vec, g_vec, h_vec  output  16 each  captured truth tables; bit n holds the response for combination n.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SWEEP and DONE.
REQ-012 IDLE -> SWEEP SHALL occur on the edge where start=1; on that edge index, the dwell counter and f_vec/g_vec/h_vec SHALL clear to 0.
REQ-013 In SWEEP, {A,B,C,D} SHALL equal index combinationally from the registered index, with no extra latency.
REQ-014 The dwell counter SHALL count 0..DWELL-1 per combination.
REQ-015 On the edge where dwell counter = DWELL-1, f, g, h SHALL be written into bit [index] of f_vec, g_vec, h_vec, the counter SHALL return to 0, and index SHALL increment.
REQ-016 Capture on the edge where index=15 and dwell counter = DWELL-1 SHALL cause the transition SWEEP -> DONE; index SHALL wrap to 0 and SHALL NOT apply a 17th combination.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 only in SWEEP, for exactly 16*DWELL cycles per sweep.
REQ-019 start SHALL be ignored in SWEEP and in DONE, with no restart and no result clear.
REQ-020 start held high continuously SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-021 f_vec/g_vec/h_vec SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-022 Result bits not yet captured in SWEEP SHALL read 0.
REQ-023 With DWELL=1, the block SHALL capture every cycle, giving a 16-cycle busy window.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL enter IDLE, and index, the dwell counter, A, B, C, D, busy, done, f_vec, g_vec and h_vec SHALL all be 0.
REQ-025 Reset SHALL take priority over start and over any in-progress capture.
REQ-026 Reset mid-sweep SHALL abort the sweep with no done pulse and all partial results cleared.
REQ-027 The first start after reset deasserts SHALL be accepted normally.

Verification
Downstream stub for all scenarios: f=A, g=D, h=B&C.
REQ-028 DWELL=2, one-cycle start pulse after reset -> busy=1 for 32 cycles, then done=1 for 1 cycle; f_vec=16'hFF00, g_vec=16'hAAAA, h_vec=16'hC0C0.
REQ-029 DWELL=2, sweep observation -> index holds each value 0..15 for exactly 2 cycles in order, and {A,B,C,D}=index on every busy cycle.
REQ-030 DWELL=1, start held high for 40 cycles -> back-to-back sweeps of busy 16, done 1, one IDLE cycle, then busy again; results identical each time.
REQ-031 DWELL=2, reset=1 for one cycle when index=7 -> all outputs 0 on the next cycle, no done pulse; the next start yields the full REQ-028 results.
REQ-032 DWELL=3, start pulsed again at busy cycle 10 and during DONE -> no restart; busy window stays 48 cycles; results unchanged.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Walks a downstream 4-input combinational block through all 16 input
// combinations. Each combination is held for DWELL clock cycles. On the last
// cycle of each hold, the three responses f/g/h are captured into the bit of
// f_vec/g_vec/h_vec that matches the combination. One extra DONE cycle ends
// each sweep.
//
// Ports
//   clk            single clock; all state changes on its rising edge
//   reset          synchronous, active-high; clears the FSM and all results
//   start          begins a 16-combination sweep; only accepted in IDLE
//   A, B, C, D     stimulus to the downstream block; A is the index MSB
//   f, g, h        responses from the downstream block
//   busy           high for the 16*DWELL cycles of a sweep
//   done           one-cycle pulse after the final capture
//   index          combination currently applied ({A,B,C,D})
//   f_vec, g_vec, h_vec  captured truth tables; bit n = response to combination n
module truth_table_sweeper #(
    parameter int DWELL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        f,
    input  logic        g,
    input  logic        h,
    output logic        busy,
    output logic        done,
    output logic [3:0]  index,
    output logic [15:0] f_vec,
    output logic [15:0] g_vec,
    output logic [15:0] h_vec
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] dwell_cnt;
    logic       last_tick;
    logic       last_combo;

    assign last_tick  = (dwell_cnt == DWELL_LAST);
    assign last_combo = (index == 4'd15);

    // Stimulus comes straight from the registered index so the downstream
    // block sees each combination for the full dwell window.
    assign {A, B, C, D} = index;

    assign busy = (state_q == SWEEP);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (last_tick && last_combo) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index     <= 4'd0;
            dwell_cnt <= 8'd0;
            f_vec     <= 16'd0;
            g_vec     <= 16'd0;
            h_vec     <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Results persist in IDLE and are only wiped when a new
                    // sweep is actually accepted.
                    if (start) begin
                        index     <= 4'd0;
                        dwell_cnt <= 8'd0;
                        f_vec     <= 16'd0;
                        g_vec     <= 16'd0;
                        h_vec     <= 16'd0;
                    end
                end
                SWEEP: begin
                    if (last_tick) begin
                        f_vec[index] <= f;
                        g_vec[index] <= g;
                        h_vec[index] <= h;
                        dwell_cnt    <= 8'd0;
                        // Natural 4-bit wrap returns index to 0 after 15, so
                        // no 17th combination is ever presented.
                        index        <= index + 4'd1;
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic            clk;
    logic [2:0]      rst_w;
    logic [2:0]      st_w;
    logic [2:0]      a_w, b_w, c_w, d_w;
    logic [2:0]      f_w, g_w, h_w;
    logic [2:0]      busy_w, done_w;
    logic [2:0][3:0]  idx_w;
    logic [2:0][15:0] fv_w, gv_w, hv_w;

    int total;
    int bad;

    localparam logic [15:0] EXP_F = 16'hFF00;
    localparam logic [15:0] EXP_G = 16'hAAAA;
    localparam logic [15:0] EXP_H = 16'hC0C0;

    // Downstream stub: f=A, g=D, h=B&C
    assign f_w = a_w;
    assign g_w = d_w;
    assign h_w = b_w & c_w;

    // Instance 0: DWELL=2, instance 1: DWELL=1, instance 2: DWELL=3
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DW = (k == 0) ? 2 : ((k == 1) ? 1 : 3);
        truth_table_sweeper #(.DWELL(DW)) dut (
            .clk   (clk),
            .reset (rst_w[k]),
            .start (st_w[k]),
            .A     (a_w[k]),
            .B     (b_w[k]),
            .C     (c_w[k]),
            .D     (d_w[k]),
            .f     (f_w[k]),
            .g     (g_w[k]),
            .h     (h_w[k]),
            .busy  (busy_w[k]),
            .done  (done_w[k]),
            .index (idx_w[k]),
            .f_vec (fv_w[k]),
            .g_vec (gv_w[k]),
            .h_vec (hv_w[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, ".index"}, 32'(idx_w[k]), 32'd0);
        check({tag, ".abcd"}, 32'({a_w[k], b_w[k], c_w[k], d_w[k]}), 32'd0);
        check({tag, ".busy"}, 32'(busy_w[k]), 32'd0);
        check({tag, ".done"}, 32'(done_w[k]), 32'd0);
        check({tag, ".f_vec"}, 32'(fv_w[k]), 32'd0);
        check({tag, ".g_vec"}, 32'(gv_w[k]), 32'd0);
        check({tag, ".h_vec"}, 32'(hv_w[k]), 32'd0);
    endtask

    // Called at the negedge of the first busy cycle. Follows the sweep to its
    // end, then checks the DONE cycle and the following IDLE cycle.
    task automatic watch_sweep(input int k, input int dwell, input string tag,
                               input int pulse_at, input bit poke_done);
        int n;
        int cap;
        bit ok_seq;
        bit ok_part;
        logic [31:0] m;
        n       = 0;
        ok_seq  = 1'b1;
        ok_part = 1'b1;
        while (busy_w[k] && n < 400) begin
            cap = n / dwell;
            m   = (32'd1 << cap) - 32'd1;
            if (idx_w[k] != 4'(cap)) ok_seq = 1'b0;
            if ({a_w[k], b_w[k], c_w[k], d_w[k]} != idx_w[k]) ok_seq = 1'b0;
            if (fv_w[k] != (EXP_F & m[15:0])) ok_part = 1'b0;
            if (gv_w[k] != (EXP_G & m[15:0])) ok_part = 1'b0;
            if (hv_w[k] != (EXP_H & m[15:0])) ok_part = 1'b0;
            if (done_w[k]) ok_seq = 1'b0;
            if (pulse_at >= 0) st_w[k] = (n == pulse_at);
            n++;
            @(negedge clk);
        end
        if (pulse_at >= 0) st_w[k] = 1'b0;
        check({tag, ".busy_len"}, 32'(n), 32'(16 * dwell));
        check({tag, ".index_seq"}, 32'(ok_seq), 32'd1);
        check({tag, ".partial"}, 32'(ok_part), 32'd1);
        check({tag, ".done_pulse"}, 32'(done_w[k]), 32'd1);
        check({tag, ".index_wrap"}, 32'(idx_w[k]), 32'd0);
        check({tag, ".f_vec"}, 32'(fv_w[k]), 32'(EXP_F));
        check({tag, ".g_vec"}, 32'(gv_w[k]), 32'(EXP_G));
        check({tag, ".h_vec"}, 32'(hv_w[k]), 32'(EXP_H));
        if (poke_done) st_w[k] = 1'b1;
        @(negedge clk);
        if (poke_done) st_w[k] = 1'b0;
        check({tag, ".idle_done"}, 32'(done_w[k]), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy_w[k]), 32'd0);
        check({tag, ".idle_f_hold"}, 32'(fv_w[k]), 32'(EXP_F));
        check({tag, ".idle_h_hold"}, 32'(hv_w[k]), 32'(EXP_H));
    endtask

    task automatic pulse_start(input int k);
        st_w[k] = 1'b1;
        @(negedge clk);
        st_w[k] = 1'b0;
    endtask

    initial begin
        int guard;
        total = 0;
        bad   = 0;
        rst_w = 3'b111;
        st_w  = 3'b111;   // start asserted during reset must be ignored
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset%0d", k));
        rst_w = 3'b000;
        st_w  = 3'b000;
        @(negedge clk);
        check("post_reset_idle", 32'(busy_w[0]), 32'd0);

        // DWELL=2 single sweep
        @(negedge clk);
        pulse_start(0);
        check("d2.busy_start", 32'(busy_w[0]), 32'd1);
        watch_sweep(0, 2, "d2", -1, 1'b0);

        // DWELL=2, reset while index=7
        pulse_start(0);
        guard = 0;
        while (idx_w[0] != 4'd7 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("rst7.reached", 32'(idx_w[0]), 32'd7);
        check("rst7.partial_g", 32'(gv_w[0]), 32'h002A);
        rst_w[0] = 1'b1;
        @(negedge clk);
        rst_w[0] = 1'b0;
        check_zero(0, "rst7");
        guard = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) guard++;
        end
        check("rst7.no_done", 32'(guard), 32'd0);
        pulse_start(0);
        check("rst7.restart_busy", 32'(busy_w[0]), 32'd1);
        watch_sweep(0, 2, "rst7.sweep", -1, 1'b0);

        // DWELL=1, start held high: back-to-back sweeps
        st_w[1] = 1'b1;
        @(negedge clk);
        check("d1.busy_start", 32'(busy_w[1]), 32'd1);
        watch_sweep(1, 1, "d1a", -1, 1'b0);
        @(negedge clk);
        check("d1.rebusy", 32'(busy_w[1]), 32'd1);
        watch_sweep(1, 1, "d1b", -1, 1'b0);
        st_w[1] = 1'b0;
        @(negedge clk);
        check("d1.stop", 32'(busy_w[1]), 32'd0);

        // DWELL=3, extra start at busy cycle 10 and during DONE
        pulse_start(2);
        check("d3.busy_start", 32'(busy_w[2]), 32'd1);
        watch_sweep(2, 3, "d3", 10, 1'b1);
        @(negedge clk);
        check("d3.no_restart", 32'(busy_w[2]), 32'd0);
        check("d3.f_hold", 32'(fv_w[2]), 32'(EXP_F));
        check("d3.g_hold", 32'(gv_w[2]), 32'(EXP_G));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
